// File: rtl/fir_controller_if.sv
// fir_controller_if: sample/coefficient inputs, result outputs and the 1k-counter handshake of the FIR controller.
// Latency: none; this interface only bundles wires.
// Backpressure: modwait tells the master when data_ready/coeff_ld would be dropped.
interface fir_controller_if #(
  parameter int DATA_W = 16
);
  logic              data_ready;
  logic [DATA_W-1:0] sample_data;
  logic              coeff_ld;
  logic [DATA_W-1:0] coeff_in;
  logic              new_coeff_set;
  logic              one_k_samples;
  logic              modwait;
  logic [DATA_W:0]   fir_out;
  logic              fir_valid;
  logic              cnt_up;
  logic              clear;
  logic              err;
  logic              batch_done;

  // Controller side.
  modport slave (
    input  data_ready, sample_data, coeff_ld, coeff_in, new_coeff_set, one_k_samples,
    output modwait, fir_out, fir_valid, cnt_up, clear, err, batch_done
  );

  // Sample source / coefficient loader / counter side.
  modport master (
    output data_ready, sample_data, coeff_ld, coeff_in, new_coeff_set, one_k_samples,
    input  modwait, fir_out, fir_valid, cnt_up, clear, err, batch_done
  );
endinterface

// File: rtl/fir_controller.sv
// fir_controller: coefficient store plus NUM_TAPS-tap multiply-accumulate sequencer ahead of the 1k sample counter.
// Latency: fir_out/fir_valid/cnt_up appear NUM_TAPS+2 cycles after the accepting data_ready (6 at default).
// Backpressure: modwait high while busy; data_ready/coeff_ld arriving then are dropped and set the sticky err.
module fir_controller #(
  parameter int DATA_W   = 16,
  parameter int NUM_TAPS = 4
) (
  input logic             clk,
  input logic             n_rst,
  fir_controller_if.slave bus_if
);

  localparam int IDX_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COEFF = 3'd1,
    S_STORE = 3'd2,
    S_MAC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [NUM_TAPS-1:0][DATA_W-1:0] coeff_q, coeff_d;
  logic [NUM_TAPS-1:0][DATA_W-1:0] taps_q, taps_d;
  logic [ACC_W-1:0]                acc_q, acc_d;
  logic [IDX_W-1:0]                cidx_q, cidx_d;
  logic [IDX_W-1:0]                kidx_q, kidx_d;
  logic [DATA_W:0]                 fir_out_q, fir_out_d;
  logic                            err_q, err_d;
  logic                            batch_q, batch_d;

  logic                            busy_c;
  logic                            done_c;
  logic                            clear_c;
  logic                            req_any;
  logic [PROD_W-1:0]               prod;
  logic [ACC_W-1:0]                acc_sum;
  logic                            acc_ovf;
  logic [DATA_W:0]                 acc_scaled;

  assign req_any = bus_if.data_ready | bus_if.coeff_ld;

  // One MAC term for the tap selected by kidx_q, plus the Q1.15 rescale/saturate of the running sum.
  always_comb begin
    prod       = PROD_W'(coeff_q[kidx_q]) * PROD_W'(taps_q[kidx_q]);
    acc_sum    = acc_q + ACC_W'(prod);
    acc_ovf    = |acc_sum[ACC_W-1:PROD_W];
    acc_scaled = acc_ovf ? {(DATA_W+1){1'b1}} : acc_sum[PROD_W-1:DATA_W-1];
  end

  // Next-state and output decode; new_coeff_set is applied last so it overrides every state.
  always_comb begin
    state_d   = state_q;
    coeff_d   = coeff_q;
    taps_d    = taps_q;
    acc_d     = acc_q;
    cidx_d    = cidx_q;
    kidx_d    = kidx_q;
    fir_out_d = fir_out_q;
    err_d     = err_q;
    batch_d   = batch_q;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    clear_c   = 1'b0;

    if (bus_if.one_k_samples) begin
      batch_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus_if.coeff_ld) begin
          // The coefficient is written on the accepting edge, while coeff_in is still valid.
          coeff_d[cidx_q] = bus_if.coeff_in;
          cidx_d          = (cidx_q == LAST_IDX) ? '0 : cidx_q + 1'b1;
          state_d         = S_COEFF;
          if (bus_if.data_ready) begin
            err_d = 1'b1;
          end
        end else if (bus_if.data_ready) begin
          // Shift the delay line on the accepting edge so sample_data is captured in its valid cycle.
          for (int k = NUM_TAPS - 1; k > 0; k--) begin
            taps_d[k] = taps_q[k-1];
          end
          taps_d[0] = bus_if.sample_data;
          state_d   = S_STORE;
        end
      end

      S_COEFF: begin
        busy_c  = 1'b1;
        state_d = S_IDLE;
        if (req_any) begin
          err_d = 1'b1;
        end
      end

      S_STORE: begin
        busy_c  = 1'b1;
        acc_d   = '0;
        kidx_d  = '0;
        state_d = S_MAC;
        if (req_any) begin
          err_d = 1'b1;
        end
      end

      S_MAC: begin
        busy_c = 1'b1;
        acc_d  = acc_sum;
        if (req_any) begin
          err_d = 1'b1;
        end
        if (kidx_q == LAST_IDX) begin
          // Register the result on the last term so it is already visible alongside fir_valid in DONE.
          fir_out_d = acc_scaled;
          if (acc_ovf) begin
            err_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          kidx_d = kidx_q + 1'b1;
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
        // DONE always returns to IDLE, so a request landing here is lost just like one during busy.
        if (req_any) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus_if.new_coeff_set) begin
      state_d   = S_IDLE;
      coeff_d   = coeff_q;
      taps_d    = '0;
      acc_d     = '0;
      cidx_d    = '0;
      kidx_d    = '0;
      fir_out_d = fir_out_q;
      err_d     = 1'b0;
      batch_d   = 1'b0;
      clear_c   = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= S_IDLE;
      coeff_q   <= '0;
      taps_q    <= '0;
      acc_q     <= '0;
      cidx_q    <= '0;
      kidx_q    <= '0;
      fir_out_q <= '0;
      err_q     <= 1'b0;
      batch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      coeff_q   <= coeff_d;
      taps_q    <= taps_d;
      acc_q     <= acc_d;
      cidx_q    <= cidx_d;
      kidx_q    <= kidx_d;
      fir_out_q <= fir_out_d;
      err_q     <= err_d;
      batch_q   <= batch_d;
    end
  end

  // Decoded strobes are masked while reset is held so every output reads 0 during reset.
  assign bus_if.modwait    = busy_c  & ~n_rst;
  assign bus_if.fir_valid  = done_c  & ~n_rst;
  assign bus_if.cnt_up     = done_c  & ~n_rst;
  assign bus_if.clear      = clear_c & ~n_rst;
  assign bus_if.fir_out    = fir_out_q;
  assign bus_if.err        = err_q;
  assign bus_if.batch_done = batch_q;

endmodule

// File: tb/tb_fir_controller.sv
// tb_fir_controller: directed bench for fir_controller with a behavioural 1k sample counter attached.
// Latency: checks the 6-cycle data_ready -> fir_valid spacing at default parameters.
// Backpressure: exercises dropped requests while modwait is high.
module tb_fir_controller;
  localparam int DATA_W   = 16;
  localparam int NUM_TAPS = 4;

  logic clk = 1'b0;
  logic n_rst;
  int   tests = 0;
  int   fails = 0;

  fir_controller_if #(.DATA_W(DATA_W)) bus_if ();

  fir_controller #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  // Behavioural 1k sample counter: counts cnt_up, pulses one_k_samples on the 1000th and self-clears.
  int   k_cnt = 0;
  logic ok_q  = 1'b0;
  always @(posedge clk) begin
    if (n_rst || bus_if.clear) begin
      k_cnt <= 0;
      ok_q  <= 1'b0;
    end else if (bus_if.cnt_up) begin
      if (k_cnt == 999) begin
        k_cnt <= 0;
        ok_q  <= 1'b1;
      end else begin
        k_cnt <= k_cnt + 1;
        ok_q  <= 1'b0;
      end
    end else begin
      ok_q <= 1'b0;
    end
  end
  assign bus_if.one_k_samples = ok_q;

  // Pulse monitor for the batch scenario.
  logic mon_en = 1'b0;
  int   mon_cu = 0;
  int   mon_ok = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_if.cnt_up)        mon_cu++;
      if (bus_if.one_k_samples) mon_ok++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nc;
    bus_if.new_coeff_set = 1'b1;
    tick();
    bus_if.new_coeff_set = 1'b0;
  endtask

  task automatic load_coeff(input logic [DATA_W-1:0] v);
    bus_if.coeff_in = v;
    bus_if.coeff_ld = 1'b1;
    tick();
    bus_if.coeff_ld = 1'b0;
    tick();
  endtask

  // Presents one sample and watches a fixed 9-cycle window; extra_at re-asserts data_ready at cycle N+extra_at.
  task automatic send_sample(input logic [DATA_W-1:0] v, input int extra_at,
                             output int lat, output logic [DATA_W:0] out,
                             output int nvalid, output logic cu);
    lat    = -1;
    out    = '0;
    nvalid = 0;
    cu     = 1'b0;
    bus_if.sample_data = v;
    bus_if.data_ready  = 1'b1;
    tick();
    bus_if.data_ready  = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == extra_at) bus_if.data_ready = 1'b1;
      if (bus_if.fir_valid === 1'b1) begin
        nvalid++;
        if (lat < 0) begin
          lat = i;
          out = bus_if.fir_out;
          cu  = bus_if.cnt_up;
        end
      end
      tick();
      bus_if.data_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    int               lat, nv, seen;
    logic [DATA_W:0]  out;
    logic             cu;
    logic [6:0]       flags;
    n_rst = 1'b1;
    tick();
    tick();
    flags = {bus_if.modwait, bus_if.fir_valid, bus_if.cnt_up, bus_if.clear,
             bus_if.err, bus_if.batch_done, bus_if.one_k_samples};
    tests++;
    if (flags !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000000", flags);
    end
    tests++;
    if (bus_if.fir_out !== '0) begin
      fails++;
      $display("FAIL reset_fir_out: got %0h expected 0", bus_if.fir_out);
    end
    n_rst = 1'b0;
    tick();
    // Start a sample, then reset at N+3 (mid-MAC) for two cycles.
    bus_if.sample_data = 16'd123;
    bus_if.data_ready  = 1'b1;
    tick();
    bus_if.data_ready  = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    flags = {bus_if.modwait, bus_if.fir_valid, bus_if.cnt_up, bus_if.clear,
             bus_if.err, bus_if.batch_done, 1'b0};
    tests++;
    if (flags !== 7'b0) begin
      fails++;
      $display("FAIL reset_midmac_flags: got %b expected 0000000", flags);
    end
    n_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.fir_valid === 1'b1) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_abort_valid: got %0d pulses expected 0", seen);
    end
    // Coefficients were cleared by reset, so any sample filters to 0.
    send_sample(16'd9, 0, lat, out, nv, cu);
    tests++;
    if (lat !== 6 || out !== '0) begin
      fails++;
      $display("FAIL reset_post_sample: got lat %0d out %0h expected lat 6 out 0", lat, out);
    end
  endtask

  task automatic test_unity_filter;
    logic [DATA_W-1:0] smp [4];
    logic [DATA_W:0]   exp_out [4];
    int                lat, nv;
    logic [DATA_W:0]   out;
    logic              cu;
    smp     = '{16'd100, 16'd200, 16'd300, 16'd400};
    exp_out = '{17'd100, 17'd300, 17'd600, 17'd1000};
    nc();
    for (int i = 0; i < 4; i++) load_coeff(16'h8000);
    for (int i = 0; i < 4; i++) begin
      send_sample(smp[i], 0, lat, out, nv, cu);
      tests++;
      if (out !== exp_out[i]) begin
        fails++;
        $display("FAIL unity_out[%0d]: got %0d expected %0d", i, out, exp_out[i]);
      end
      tests++;
      if (lat !== 6 || cu !== 1'b1 || nv !== 1) begin
        fails++;
        $display("FAIL unity_timing[%0d]: got lat %0d cnt_up %b valids %0d expected lat 6 cnt_up 1 valids 1",
                 i, lat, cu, nv);
      end
    end
  endtask

  task automatic test_saturation;
    logic [DATA_W:0] exp_out [4];
    int              lat, nv;
    logic [DATA_W:0] out;
    logic            cu;
    exp_out = '{17'h1FFFC, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
    nc();
    for (int i = 0; i < 4; i++) load_coeff(16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      send_sample(16'hFFFF, 0, lat, out, nv, cu);
      tests++;
      if (out !== exp_out[i]) begin
        fails++;
        $display("FAIL sat_out[%0d]: got %0h expected %0h", i, out, exp_out[i]);
      end
      if (i == 0) begin
        tests++;
        if (bus_if.err !== 1'b0) begin
          fails++;
          $display("FAIL sat_err_first: got %b expected 0", bus_if.err);
        end
      end
    end
    tests++;
    if (bus_if.err !== 1'b1) begin
      fails++;
      $display("FAIL sat_err: got %b expected 1", bus_if.err);
    end
  endtask

  task automatic test_drop;
    int              lat, nv;
    logic [DATA_W:0] out;
    logic            cu;
    nc();
    for (int i = 0; i < 4; i++) load_coeff(16'h8000);
    tests++;
    if (bus_if.err !== 1'b0) begin
      fails++;
      $display("FAIL drop_err_pre: got %b expected 0", bus_if.err);
    end
    send_sample(16'd5, 2, lat, out, nv, cu);
    tests++;
    if (nv !== 1 || out !== 17'd5 || bus_if.err !== 1'b1) begin
      fails++;
      $display("FAIL drop_busy: got valids %0d out %0d err %b expected valids 1 out 5 err 1",
               nv, out, bus_if.err);
    end
    bus_if.new_coeff_set = 1'b1;
    #1;
    tests++;
    if (bus_if.clear !== 1'b1) begin
      fails++;
      $display("FAIL drop_clear_pulse: got %b expected 1", bus_if.clear);
    end
    tick();
    bus_if.new_coeff_set = 1'b0;
    #1;
    tests++;
    if (bus_if.err !== 1'b0 || bus_if.clear !== 1'b0) begin
      fails++;
      $display("FAIL drop_after_ncs: got err %b clear %b expected err 0 clear 0", bus_if.err, bus_if.clear);
    end
    // Taps were zeroed, so the old sample 5 must not contribute.
    send_sample(16'd7, 0, lat, out, nv, cu);
    tests++;
    if (out !== 17'd7) begin
      fails++;
      $display("FAIL drop_taps_zero: got %0d expected 7", out);
    end
    // data_ready together with coeff_ld in IDLE: coefficient load wins, sample dropped.
    bus_if.coeff_in    = 16'h8000;
    bus_if.sample_data = 16'd99;
    bus_if.coeff_ld    = 1'b1;
    bus_if.data_ready  = 1'b1;
    tick();
    bus_if.coeff_ld    = 1'b0;
    bus_if.data_ready  = 1'b0;
    tests++;
    if (bus_if.modwait !== 1'b1 || bus_if.err !== 1'b1) begin
      fails++;
      $display("FAIL drop_coincident: got modwait %b err %b expected modwait 1 err 1",
               bus_if.modwait, bus_if.err);
    end
    tick();
  endtask

  task automatic test_coeff_wrap;
    int              lat, nv;
    logic [DATA_W:0] out;
    logic            cu;
    nc();
    load_coeff(16'h2000);
    load_coeff(16'h4000);
    load_coeff(16'h0000);
    load_coeff(16'h0000);
    load_coeff(16'h8000);
    // coeff = {1.0, 0.5, 0, 0}: 50 -> 50, then 10 + 50*0.5 -> 35.
    send_sample(16'd50, 0, lat, out, nv, cu);
    tests++;
    if (out !== 17'd50) begin
      fails++;
      $display("FAIL wrap_first: got %0d expected 50", out);
    end
    send_sample(16'd10, 0, lat, out, nv, cu);
    tests++;
    if (out !== 17'd35) begin
      fails++;
      $display("FAIL wrap_second: got %0d expected 35", out);
    end
  endtask

  task automatic test_batch;
    int              lat, nv;
    logic [DATA_W:0] out;
    logic            cu;
    nc();
    mon_cu = 0;
    mon_ok = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 999; i++) send_sample(16'd1, 0, lat, out, nv, cu);
    tests++;
    if (bus_if.batch_done !== 1'b0 || mon_ok !== 0) begin
      fails++;
      $display("FAIL batch_early: got batch_done %b rollovers %0d expected 0 and 0", bus_if.batch_done, mon_ok);
    end
    send_sample(16'd1, 0, lat, out, nv, cu);
    tick();
    tick();
    mon_en = 1'b0;
    tests++;
    if (mon_cu !== 1000 || mon_ok !== 1) begin
      fails++;
      $display("FAIL batch_counts: got cnt_up %0d rollovers %0d expected 1000 and 1", mon_cu, mon_ok);
    end
    tests++;
    if (bus_if.batch_done !== 1'b1) begin
      fails++;
      $display("FAIL batch_done: got %b expected 1", bus_if.batch_done);
    end
  endtask

  initial begin
    n_rst                = 1'b1;
    bus_if.data_ready    = 1'b0;
    bus_if.sample_data   = '0;
    bus_if.coeff_ld      = 1'b0;
    bus_if.coeff_in      = '0;
    bus_if.new_coeff_set = 1'b0;
    test_reset();
    test_unity_filter();
    test_saturation();
    test_drop();
    test_coeff_wrap();
    test_batch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
